// File: rtl/code_group_aligner_if.sv
// rtl/code_group_aligner_if.sv - line-bit input and framed code-group output bundle
interface code_group_aligner_if #(
    parameter int CG_WIDTH = 10
);
    logic                rx_bit;
    logic                rx_bit_valid;
    logic                code_sync_status;
    logic [CG_WIDTH-1:0] pudi;
    logic                indicate;
    logic                aligned;
    logic                realign;

    modport master (
        output rx_bit, rx_bit_valid, code_sync_status,
        input  pudi, indicate, aligned, realign
    );

    modport slave (
        input  rx_bit, rx_bit_valid, code_sync_status,
        output pudi, indicate, aligned, realign
    );
endinterface

// File: rtl/code_group_aligner.sv
// rtl/code_group_aligner.sv - comma-based bit-serial code-group framer
module code_group_aligner #(
    parameter int CG_WIDTH    = 10,
    parameter int LOCK_COMMAS = 3,
    parameter int MISS_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 mr_main_reset,
    code_group_aligner_if.slave  bus
);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COMMAS);
    localparam logic [3:0] MISS_N   = 4'(MISS_LIMIT);
    localparam logic [3:0] LAST_BIT = 4'(CG_WIDTH - 1);
    localparam logic [3:0] FILL_MAX = 4'(CG_WIDTH);

    state_t              state_q;
    logic [CG_WIDTH-1:0] sreg_q;
    logic [CG_WIDTH-1:0] sreg_d;
    logic [3:0]          bit_cnt_q;
    logic [3:0]          bit_cnt_d;
    logic [3:0]          fill_q;
    logic [3:0]          conf_cnt_q;
    logic [3:0]          miss_cnt_q;
    logic                sync_q;
    logic [CG_WIDTH-1:0] pudi_q;
    logic                indicate_q;
    logic                aligned_q;
    logic                realign_q;

    logic at_bnd;
    logic comma;
    logic sync_loss;

    always_comb begin
        sreg_d    = {sreg_q[CG_WIDTH-2:0], bus.rx_bit};
        at_bnd    = (bit_cnt_q == LAST_BIT);
        bit_cnt_d = at_bnd ? 4'd0 : bit_cnt_q + 4'd1;
        // the bit being shifted now completes the fill when fill_q is one short
        comma     = (fill_q >= LAST_BIT) &&
                    ((sreg_d[CG_WIDTH-1:CG_WIDTH-7] == 7'b0011111) ||
                     (sreg_d[CG_WIDTH-1:CG_WIDTH-7] == 7'b1100000));
        sync_loss = sync_q && !bus.code_sync_status;
    end

    always_ff @(posedge clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q    <= SEARCH;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            fill_q     <= '0;
            conf_cnt_q <= '0;
            miss_cnt_q <= '0;
            sync_q     <= 1'b0;
            pudi_q     <= '0;
            indicate_q <= 1'b0;
            aligned_q  <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            sync_q     <= bus.code_sync_status;
            indicate_q <= 1'b0;
            realign_q  <= 1'b0;
            if (bus.rx_bit_valid) begin
                sreg_q <= sreg_d;
                if (fill_q != FILL_MAX) fill_q <= fill_q + 4'd1;
            end
            // sync loss wins over any comma or emission on the same bit
            if (sync_loss) begin
                if (state_q != SEARCH) begin
                    state_q    <= SEARCH;
                    aligned_q  <= 1'b0;
                    conf_cnt_q <= '0;
                    miss_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            end else if (bus.rx_bit_valid) begin
                bit_cnt_q <= bit_cnt_d;
                case (state_q)
                    SEARCH: begin
                        if (comma) begin
                            pudi_q     <= sreg_d;
                            indicate_q <= 1'b1;
                            realign_q  <= 1'b1;
                            bit_cnt_q  <= '0;
                            conf_cnt_q <= 4'd1;
                            if (LOCK_N <= 4'd1) begin
                                state_q   <= LOCKED;
                                aligned_q <= 1'b1;
                            end else begin
                                state_q   <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (comma && !at_bnd) begin
                            pudi_q     <= sreg_d;
                            indicate_q <= 1'b1;
                            realign_q  <= 1'b1;
                            bit_cnt_q  <= '0;
                            conf_cnt_q <= 4'd1;
                        end else if (at_bnd) begin
                            pudi_q     <= sreg_d;
                            indicate_q <= 1'b1;
                            if (comma) begin
                                conf_cnt_q <= conf_cnt_q + 4'd1;
                                if (conf_cnt_q + 4'd1 >= LOCK_N) begin
                                    state_q    <= LOCKED;
                                    aligned_q  <= 1'b1;
                                    miss_cnt_q <= '0;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (comma && !at_bnd) begin
                            if (miss_cnt_q + 4'd1 >= MISS_N) begin
                                pudi_q     <= sreg_d;
                                indicate_q <= 1'b1;
                                realign_q  <= 1'b1;
                                bit_cnt_q  <= '0;
                                conf_cnt_q <= 4'd1;
                                miss_cnt_q <= '0;
                                aligned_q  <= 1'b0;
                                state_q    <= CONFIRM;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + 4'd1;
                            end
                        end else if (at_bnd) begin
                            pudi_q     <= sreg_d;
                            indicate_q <= 1'b1;
                            if (comma) miss_cnt_q <= '0;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign bus.pudi     = pudi_q;
    assign bus.indicate = indicate_q;
    assign bus.aligned  = aligned_q;
    assign bus.realign  = realign_q;

endmodule

// File: tb/tb_code_group_aligner.sv
// tb/tb_code_group_aligner.sv - directed bench for code_group_aligner
module tb_code_group_aligner;

    localparam logic [9:0] K = 10'b0011111010;
    localparam logic [9:0] D = 10'b1001000101;

    logic clk = 1'b0;
    logic rst;

    code_group_aligner_if #(.CG_WIDTH(10)) bus ();

    code_group_aligner #(
        .CG_WIDTH   (10),
        .LOCK_COMMAS(3),
        .MISS_LIMIT (4)
    ) dut (
        .clk          (clk),
        .mr_main_reset(rst),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ind_cnt = 0;
    int rl_cnt = 0;
    int bad_pair = 0;
    int bad_idle = 0;
    int spacing_bad = 0;
    int since = 0;
    int seq_err;
    logic       al_first;
    logic [9:0] last_pudi;
    logic [9:0] pq[$];
    logic [9:0] w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx_bit       = b;
        bus.rx_bit_valid = 1'b1;
        @(posedge clk);
        #1;
        since++;
        if (bus.realign && !bus.indicate) bad_pair++;
        if (bus.indicate) begin
            ind_cnt++;
            last_pudi = bus.pudi;
            pq.push_back(bus.pudi);
            if (bus.realign) rl_cnt++;
            else if (since != 10) spacing_bad++;
            since = 0;
        end
    endtask

    task automatic idle(input int n);
        bus.rx_bit_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.indicate || bus.realign) bad_idle++;
        end
    endtask

    task automatic send_word(input logic [9:0] word, input int gap_max);
        for (int i = 9; i >= 0; i--) begin
            send_bit(word[i]);
            if (i == 9) al_first = bus.aligned;
            if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic clear();
        ind_cnt = 0;
        rl_cnt  = 0;
        pq.delete();
    endtask

    task automatic do_reset();
        bus.rx_bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        since = 0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.rx_bit           = 1'b0;
        bus.rx_bit_valid     = 1'b0;
        bus.code_sync_status = 1'b1;
        #2;
        check("reset_pudi", 32'(bus.pudi), 32'h0);
        check("reset_outs", {29'd0, bus.indicate, bus.aligned, bus.realign}, 32'h0);
        do_reset();

        clear();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(K, 0);
        check("acq_first_ind", ind_cnt, 1);
        check("acq_first_pudi", 32'(last_pudi), 32'(K));
        check("acq_first_realign", rl_cnt, 1);
        check("acq_first_aligned", 32'(bus.aligned), 0);
        send_word(D, 0);
        check("acq_d_pudi", 32'(last_pudi), 32'(D));
        send_word(K, 0);
        check("acq_2nd_aligned", 32'(bus.aligned), 0);
        send_word(D, 0);
        send_word(K, 0);
        check("acq_3rd_pre_aligned", 32'(al_first), 0);
        check("acq_3rd_aligned", 32'(bus.aligned), 1);
        check("acq_ind_count", ind_cnt, 5);
        send_word(D, 0);
        check("acq_realign_count", rl_cnt, 1);

        send_bit(1'b1);
        for (int m = 0; m < 3; m++) begin
            send_word(K, 0);
            send_word(D, 0);
            check("slip_hold_aligned", 32'(bus.aligned), 1);
        end
        check("slip_no_realign", rl_cnt, 1);
        send_word(K, 0);
        check("slip_realign", rl_cnt, 2);
        check("slip_drop_aligned", 32'(bus.aligned), 0);
        check("slip_realign_pudi", 32'(last_pudi), 32'(K));
        send_word(D, 0);
        check("slip_d_pudi", 32'(last_pudi), 32'(D));
        send_word(K, 0);
        check("slip_conf2_aligned", 32'(bus.aligned), 0);
        send_word(D, 0);
        send_word(K, 0);
        check("slip_relock", 32'(bus.aligned), 1);
        send_word(D, 0);

        clear();
        bus.code_sync_status = 1'b0;
        send_word(D, 0);
        check("sync_loss_aligned", 32'(al_first), 0);
        check("sync_loss_no_ind", ind_cnt, 0);
        bus.code_sync_status = 1'b1;
        send_word(K, 0);
        check("sync_loss_reacq_ind", ind_cnt, 1);
        check("sync_loss_reacq_realign", rl_cnt, 1);
        check("sync_loss_reacq_pudi", 32'(last_pudi), 32'(K));
        send_word(D, 0); send_word(K, 0); send_word(D, 0); send_word(K, 0);
        check("pre_reset_aligned", 32'(bus.aligned), 1);

        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        #2;
        bus.rx_bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_pudi", 32'(bus.pudi), 32'h0);
        check("midreset_outs", {29'd0, bus.indicate, bus.aligned, bus.realign}, 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        since = 0;
        clear();
        send_word(D, 0);
        send_word(D, 0);
        check("midreset_no_ind", ind_cnt, 0);
        send_word(K, 0);
        check("midreset_reacq_ind", ind_cnt, 1);
        check("midreset_reacq_pudi", 32'(last_pudi), 32'(K));

        do_reset();
        clear();
        w = 10'b0011111010;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        check("fill_no_early_ind", ind_cnt, 0);
        send_word(K, 0);
        check("fill_ind_count", ind_cnt, 1);
        check("fill_pudi", 32'(last_pudi), 32'(K));

        do_reset();
        clear();
        send_bit(1'b1); idle(2); send_bit(1'b0); idle(1); send_bit(1'b1);
        for (int p = 0; p < 4; p++) begin
            send_word(K, 3);
            send_word(D, 3);
        end
        check("gap_ind_count", pq.size(), 8);
        seq_err = 0;
        for (int i = 0; i < pq.size(); i++) begin
            if (pq[i] !== ((i % 2 == 0) ? K : D)) seq_err++;
        end
        check("gap_pudi_sequence", seq_err, 0);
        check("gap_aligned", 32'(bus.aligned), 1);
        check("idle_no_strobe", bad_idle, 0);
        check("strobe_spacing", spacing_bad, 0);
        check("realign_with_indicate", bad_pair, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/code_group_aligner.md
# code_group_aligner

Bit-serial receive front end of the PCS. Shifts in one recovered line bit per valid clock, finds the 7-bit comma (K28.5 prefix) and frames the stream into 10-bit code-groups. It then hands each code-group to the synchronization stage as `pudi` with a one-cycle `indicate` strobe. It acquires and holds a word boundary and reports it via `aligned`. It drops the boundary when the synchronization stage reports loss of code sync.

## Interface

**Parameters**
- `CG_WIDTH`, 10, code-group width; only 10 is legal.
- `LOCK_COMMAS`, 3, boundary-consistent commas required to declare `aligned` (1..15).
- `MISS_LIMIT`, 4, consecutive off-boundary commas tolerated while locked before realigning (1..15).

**Ports**
- `clk`  in  1  single clock; all state changes on rising edge.
- `mr_main_reset`  in  1  reset; asynchronous, active-high.
- `rx_bit`  in  1  recovered line bit; first-transmitted bit of a code-group (a) arrives first.
- `rx_bit_valid`  in  1  `rx_bit` is sampled only when high.
- `code_sync_status`  in  1  from the synchronization stage; a 1→0 edge forces re-search.
- `pudi`  out  CG_WIDTH  framed code-group, bit order {a,b,c,d,e,i,f,g,h,j}, a in bit 9.
- `indicate`  out  1  one-cycle strobe: `pudi` updated this cycle.
- `aligned`  out  1  boundary locked.
- `realign`  out  1  one-cycle strobe: boundary moved this cycle.

## Operation

- Shift register `sreg[9:0]`: on valid bit, `sreg_next = {sreg[8:0], rx_bit}`; the newest bit is at bit 0.
- Comma match: `sreg_next[9:3]` is 7'b0011111 or 7'b1100000. Matching is gated until 10 valid bits have been shifted since reset (fill counter saturates at 10).
- Bit counter `bit_cnt` runs 0..9 and advances on valid bits only. Boundary position is `bit_cnt == 9`.
- Emit = `pudi <= sreg_next`, `indicate <= 1`, `bit_cnt <= 0`.
- Realign = emit at the current bit regardless of `bit_cnt`, plus `realign <= 1`.

**States**
- SEARCH
  - No emissions.
  - A comma causes realign, `conf_cnt = 1`, then → CONFIRM. If `LOCK_COMMAS == 1`, go → LOCKED instead.
- CONFIRM
  - Emit at every boundary.
  - Comma at the boundary: `conf_cnt + 1`. On reaching `LOCK_COMMAS`, → LOCKED and `aligned <= 1`.
  - Comma off the boundary: realign, `conf_cnt = 1`, stay in CONFIRM.
- LOCKED
  - Emit at every boundary.
  - Comma at the boundary: `miss_cnt = 0`.
  - Comma off the boundary: `miss_cnt + 1`. The bit is ignored: no emission, `bit_cnt` advances normally.
  - When `miss_cnt + 1 == MISS_LIMIT`: realign, `conf_cnt = 1`, `miss_cnt = 0`, `aligned <= 0`, → CONFIRM.
- Sync-loss
  - Detection: registered `code_sync_status` was 1 and is now 0.
  - In CONFIRM or LOCKED: → SEARCH, `aligned <= 0`, counters cleared.
  - Sync-loss has priority over any comma or emission in the same cycle; that bit is shifted but not acted on.
- Idle cycles: `rx_bit_valid` low holds `sreg`, `bit_cnt`, `pudi` and state. `indicate` and `realign` return to 0. Edge detection on `code_sync_status` still runs.

## Timing

- Reset (asynchronous, any time, including mid-word):
  - Outputs: `pudi = 0`, `indicate = 0`, `aligned = 0`, `realign = 0`.
  - Internal: `sreg = 0`, `bit_cnt = 0`, fill = 0, counters = 0, state = SEARCH, sync-status register = 0.
- Latency: the bit completing a code-group is sampled at edge N. `pudi` and `indicate` are valid after edge N and are high for exactly one cycle.
- `indicate` spacing in CONFIRM/LOCKED: exactly 10 valid bits between strobes, except immediately after a realign (shorter or longer).
- `aligned` rises on the same edge as the `indicate` of the `LOCK_COMMAS`-th consistent comma. It falls on the edge of the realign or sync-loss.
- `realign` and `indicate` are always high together.

## Test plan

- **Reset mid-stream:** assert `mr_main_reset` between clock edges while LOCKED → all outputs 0 immediately; no `indicate` until a new comma arrives.
- **Acquisition:** stream K28.5− (0011111010) / D16.2 (1001000101) pairs with 3 junk leading bits → first `indicate` carries `pudi = 10'b0011111010` with `realign = 1`; then one strobe every 10 bits; `aligned = 1` on the 3rd comma's strobe.
- **Slip while locked:** insert one extra bit → 3 off-boundary commas produce no realign and `aligned` stays 1; the 4th causes realign, `aligned = 0`, then re-lock after 3 more commas.
- **Sync loss:** while LOCKED, drive `code_sync_status` 1→0 → `aligned = 0` next edge, no `indicate` until the next comma, state SEARCH.
- **Valid gaps:** randomly deassert `rx_bit_valid` → `pudi` sequence is identical to the gapless run; strobes occur only after 10 valid bits.
- **Fill guard:** after reset, feed 11111010 then K28.5 → no `indicate` before the 10th valid bit; first emission is the genuine comma.
